// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, tick-counter type, parity helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Wide enough for OVERSAMPLE up to 256 ticks per bit.
  localparam int TICK_CNT_W = 8;
  typedef logic [TICK_CNT_W-1:0] tick_cnt_t;

  // Widest supported data word; narrower words are zero-extended before use.
  localparam int MAX_DATA_W = 9;
  typedef logic [MAX_DATA_W-1:0] word_t;

  // XOR-reduction of the received data bits (zero padding does not change it).
  function automatic logic parity_of(input word_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the async rx line plus a falling-edge strobe on the synchronised value.
// Latency: 2 clk to rx_sync; rx_fall asserts in the cycle rx_sync first reads low.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), rx_serial (async in), rx_sync (synchronised), rx_fall (1-clk strobe).
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_serial,
  output logic rx_sync,
  output logic rx_fall
);

  logic rx_meta;
  logic rx_prev;

  // All flops reset to 1 so an idle (high) line never produces a spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, optional parity, 1/2 stop bits, valid/ready output register.
// Latency: data_valid rises 1 clk after the os_tick that samples the final stop bit.
// Backpressure: a single holding register; a frame finishing while it is still full pulses overrun and is dropped.
// Ports: clk, rst_n, os_tick, rx_serial in; data_out, data_valid, parity_err, frame_err, overrun out; data_ready in.
// Build option: define UART_RX_MAJORITY_EN to take each bit as the majority of 3 ticks (mid-1, mid, mid+1).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  os_tick,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam tick_cnt_t OS_END = tick_cnt_t'(OVERSAMPLE - 1);

  logic rx_sync;
  logic rx_fall;
  logic bit_s;

  uart_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rx_sync   (rx_sync),
    .rx_fall   (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // The decision tick is mid+1; the two previous ticks' samples sit in hist.
  localparam tick_cnt_t START_END = tick_cnt_t'(OVERSAMPLE / 2);
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (os_tick) begin
      hist <= {hist[0], rx_sync};
    end
  end

  assign bit_s = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
`else
  localparam tick_cnt_t START_END = tick_cnt_t'(OVERSAMPLE / 2 - 1);
  assign bit_s = rx_sync;
`endif

  rx_state_e             state;
  rx_state_e             state_next;
  tick_cnt_t             tcnt;
  logic [3:0]            bcnt;
  logic                  scnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  perr_r;
  logic                  ferr_acc;
  logic                  at_mid;
  logic                  frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    at_mid     = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_fall) state_next = START;
      end
      START: begin
        if (os_tick && tcnt == START_END) begin
          at_mid     = 1'b1;
          // Line back high at mid-start: a glitch, drop it silently.
          state_next = bit_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (os_tick && tcnt == OS_END) begin
          at_mid = 1'b1;
          if (bcnt == 4'(DATA_WIDTH - 1)) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (os_tick && tcnt == OS_END) begin
          at_mid     = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (os_tick && tcnt == OS_END) begin
          at_mid = 1'b1;
          if (scnt == 1'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt       <= '0;
      bcnt       <= '0;
      scnt       <= 1'b0;
      shift      <= '0;
      perr_r     <= 1'b0;
      ferr_acc   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // Restart the tick count at every state change and after every mid-bit sample.
      if (state_next != state || at_mid) begin
        tcnt <= '0;
      end else if (os_tick && state != IDLE) begin
        tcnt <= tcnt + 1'b1;
      end

      if (state == START && at_mid) begin
        bcnt     <= '0;
        scnt     <= 1'b0;
        perr_r   <= 1'b0;
        ferr_acc <= 1'b0;
      end

      if (state == DATA && at_mid) begin
        shift <= {bit_s, shift[DATA_WIDTH-1:1]};
        bcnt  <= bcnt + 1'b1;
      end

      if (state == PARITY && at_mid) begin
        perr_r <= (parity_of(word_t'(shift)) ^ bit_s) != (PARITY_ODD != 0);
      end

      if (state == STOP && at_mid) begin
        scnt     <= scnt + 1'b1;
        ferr_acc <= ferr_acc | ~bit_s;
      end

      // Holding register: a same-cycle accept frees the slot for the new word.
      if (frame_done) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift;
          parity_err <= perr_r;
          frame_err  <= ferr_acc | ~bit_s;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
